// File: rtl/bft_stream_packetizer.sv
// Turns a 32-bit valid/ready user stream into single-cycle BFT packets for one fixed
// destination leaf/port, gated by credits that the destination returns as freespace updates.
module bft_stream_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int DEST_LEAF             = 2,
  parameter int DEST_PORT             = 2,
  parameter int SELF_LEAF             = 6,
  parameter int CREDIT_PORT           = 0,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ap_start,
  input  logic [PAYLOAD_BITS-1:0]  din,
  input  logic                     vld_in,
  output logic                     rdy_upward,
  input  logic [PACKET_BITS-1:0]   din_bft2tx,
  output logic [PACKET_BITS-1:0]   dout_tx2bft,
  output logic [NUM_ADDR_BITS:0]   credits,
  output logic                     credit_err
);

  localparam int CRED_W      = NUM_ADDR_BITS + 1;
  localparam int SUM_W       = CRED_W + 2;
  localparam int MAX_CREDITS = 1 << NUM_ADDR_BITS;
  localparam int VALID_BIT   = PACKET_BITS - 1;
  localparam int ADDR_LSB    = PAYLOAD_BITS;
  localparam int PORT_LSB    = ADDR_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB    = PORT_LSB + NUM_PORT_BITS;

  localparam logic signed [SUM_W-1:0] MAX_CREDITS_S = SUM_W'(MAX_CREDITS);
  localparam logic signed [SUM_W-1:0] UPDATE_S      = SUM_W'(FREESPACE_UPDATE_SIZE);
  localparam logic signed [SUM_W-1:0] ONE_S         = SUM_W'(1);

  // A freespace update is any valid packet addressed to our leaf on the credit port.
  function automatic logic is_credit_return(input logic [PACKET_BITS-1:0] pkt);
    return pkt[VALID_BIT]
        && (pkt[LEAF_LSB +: NUM_LEAF_BITS] == NUM_LEAF_BITS'(SELF_LEAF))
        && (pkt[PORT_LSB +: NUM_PORT_BITS] == NUM_PORT_BITS'(CREDIT_PORT));
  endfunction

  function automatic logic [PACKET_BITS-1:0] pack_packet(
    input logic [NUM_ADDR_BITS-1:0] addr,
    input logic [PAYLOAD_BITS-1:0]  payload
  );
    return {1'b1, NUM_LEAF_BITS'(DEST_LEAF), NUM_PORT_BITS'(DEST_PORT), addr, payload};
  endfunction

  function automatic logic [CRED_W-1:0] saturate_credits(input logic signed [SUM_W-1:0] sum);
    if (sum > MAX_CREDITS_S) begin
      return CRED_W'(MAX_CREDITS);
    end else if (sum < 0) begin
      return '0;
    end else begin
      return sum[CRED_W-1:0];
    end
  endfunction

  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic [CRED_W-1:0]        credits_q, credits_d;
  logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
  logic                     started_q, started_d;
  logic                     credit_err_q, credit_err_d;

  logic                     xfer;
  logic                     credit_ret;
  logic signed [SUM_W-1:0]  cred_cur, cred_dec, cred_inc, credit_sum;
  logic                     unused_pkt_bits;

  assign unused_pkt_bits = ^din_bft2tx[PORT_LSB-1:0];

  assign rdy_upward = started_q & (credits_q != '0) & ~reset;

  always_comb begin
    xfer       = vld_in & rdy_upward;
    credit_ret = is_credit_return(din_bft2tx);

    cred_cur   = $signed(SUM_W'(credits_q));
    cred_dec   = xfer ? ONE_S : '0;
    cred_inc   = credit_ret ? UPDATE_S : '0;
    credit_sum = cred_cur - cred_dec + cred_inc;

    dout_d       = xfer ? pack_packet(addr_q, din) : '0;
    addr_d       = addr_q + NUM_ADDR_BITS'(xfer);
    started_d    = started_q | ap_start;
    credits_d    = saturate_credits(credit_sum);
    credit_err_d = credit_err_q | (credit_sum > MAX_CREDITS_S);
  end

  // Stage boundary: accepted word becomes a one-cycle packet on the BFT side.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q       <= '0;
      credits_q    <= CRED_W'(MAX_CREDITS);
      addr_q       <= '0;
      started_q    <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      credits_q    <= credits_d;
      addr_q       <= addr_d;
      started_q    <= started_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign dout_tx2bft = dout_q;
  assign credits     = credits_q;
  assign credit_err  = credit_err_q;

endmodule

// File: doc/bft_stream_packetizer.md
Name: bft_stream_packetizer

Overview:
- Transmit-side counterpart of the leaf interface's input port logic.
- Accepts a 32-bit valid/ready user stream and emits 49-bit BFT packets addressed to one fixed destination leaf/port.
- Tracks the destination's receive buffer with credit-based flow control, replenished by freespace-update packets arriving from the BFT.
- Sits between a producer (user core or write_queue output) and the BFT leaf port.

Parameters:
- PACKET_BITS, 49, total packet width.
- PAYLOAD_BITS, 32, payload width.
- NUM_LEAF_BITS, 5, leaf address field width.
- NUM_PORT_BITS, 4, port field width.
- NUM_ADDR_BITS, 7, sequence/BRAM address field width.
- DEST_LEAF, 2, destination leaf id.
- DEST_PORT, 2, destination input port id.
- SELF_LEAF, 6, own leaf id; credit packets must carry this id.
- CREDIT_PORT, 0, port field value marking a freespace-update packet.
- FREESPACE_UPDATE_SIZE, 64, credits returned per update.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ap_start  in  1  start strobe; sticky once seen.
- din  in  32  user payload.
- vld_in  in  1  payload valid.
- rdy_upward  out  1  ready to accept payload.
- din_bft2tx  in  49  packets from BFT (credit returns).
- dout_tx2bft  out  49  packets to BFT.
- credits  out  NUM_ADDR_BITS+1  current credit count.
- credit_err  out  1  sticky: credit overflow detected.

Behaviour:
- Clock is clk. reset is synchronous, active-high; all state updates on the rising edge of clk.
- Packet layout: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload.
- Reset values: dout_tx2bft=0, credits=2^NUM_ADDR_BITS (128), started=0, addr counter=0, credit_err=0.
- rdy_upward = started & (credits!=0) & ~reset. It is combinational from registers only and never depends on vld_in.
- started: set on any clk edge where ap_start=1 (reset low); cleared only by reset.
- Transfer occurs when vld_in & rdy_upward.
  - Next cycle: dout_tx2bft = {1'b1, DEST_LEAF, DEST_PORT, addr, din}.
  - addr increments, wrapping 127->0.
  - credits decrements.
- No transfer: dout_tx2bft = 0 next cycle. Each packet is a single-cycle pulse; latency is 1 cycle from accept.
- Credit return: a cycle where din_bft2tx[48]=1, leaf==SELF_LEAF and port==CREDIT_PORT. It adds FREESPACE_UPDATE_SIZE. addr and payload fields are ignored.
- Other incoming packets are ignored.
- Send and credit return in the same cycle: credits = credits - 1 + 64.
- Overflow: if the result exceeds 128, credits clamps to 128 and credit_err sets (sticky until reset).
- Credits = 0: rdy_upward=0. A credit return that cycle makes rdy_upward=1 on the next cycle.
- Reset mid-stream: the packet in flight is dropped (dout forced 0 next cycle); credits and addr restore to their reset values. Reset has priority over all events.
- Before started: no transfers. Credit returns are still applied.

Test Plan:
- Reset, then ap_start pulse, then 3 words 0xA,0xB,0xC back-to-back -> dout 1 cycle later: {1,2,2,0,0xA},{1,2,2,1,0xB},{1,2,2,2,0xC}; credits=125.
- vld_in held with no ap_start for 10 cycles -> rdy_upward=0, dout=0, credits=128.
- 128 sends with no credit return -> rdy_upward=0 after the 128th accept, addr wrapped to 0. Inject credit packet (leaf 6, port 0) -> credits=64, rdy_upward=1 next cycle, next packet addr=0.
- Send and credit return in the same cycle with credits=10 -> credits=73.
- Credit return with credits=100 -> credits=128, credit_err=1, stays set until reset.
- Reset asserted the cycle after an accept with credits=50 -> dout=0, credits=128, addr=0, started=0.
